// File: rtl/serdesphy_csr_pkg.sv
// Shared address map and field definitions for the SerDes PHY CSR bank.
package serdesphy_csr_pkg;

    // Global page addresses
    localparam logic [7:0] ADDR_ID      = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH = 8'h01;
    localparam logic [7:0] ADDR_COMMIT  = 8'h02;
    localparam logic [7:0] ADDR_IRQ_SUM = 8'h03;
    localparam logic [7:0] ADDR_GCTRL   = 8'h04;

    // Lane pages start at LANE_STRIDE and repeat every LANE_STRIDE bytes
    localparam logic [7:0] LANE_STRIDE  = 8'h10;

    // Register offsets inside a lane page
    typedef enum logic [3:0] {
        OFS_CTRL   = 4'h0,
        OFS_ACTIVE = 4'h1,
        OFS_STATUS = 4'h2,
        OFS_STICKY = 4'h3,
        OFS_MASK   = 4'h4
    } lane_ofs_e;

    // CTRL byte bit fields
    localparam int CTRL_PHY_EN  = 0;
    localparam int CTRL_TX_EN   = 1;
    localparam int CTRL_RX_EN   = 2;
    localparam int CTRL_CDR_RST = 3;
    localparam int CTRL_PLL_EN  = 4;

    // GCTRL bit fields
    localparam int GCTRL_AUTO_COMMIT = 0;

    // Base address of the register page for lane l
    function automatic logic [7:0] lane_base(input int l);
        return 8'(int'(LANE_STRIDE) * (l + 1));
    endfunction

endpackage

// File: rtl/serdesphy_csr_bank_if.sv
// Register access bus between the I2C slave front end and the CSR bank.
interface serdesphy_csr_bank_if;
    import serdesphy_csr_pkg::*;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write_en;
    logic       reg_read_en;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;
    logic       reg_err;

    modport master (
        output reg_addr, reg_wdata, reg_write_en, reg_read_en,
        input  reg_rdata, reg_rvalid, reg_err
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_write_en, reg_read_en,
        output reg_rdata, reg_rvalid, reg_err
    );
endinterface

// File: rtl/serdesphy_csr_lane.sv
// One lane page: status synchroniser, edge detect, sticky/mask and
// shadow/active control double-buffer.
module serdesphy_csr_lane
    import serdesphy_csr_pkg::*;
#(
    parameter logic [7:0] CTRL_RST = 8'h14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] status_raw,
    input  logic [7:0] wdata,
    input  logic       shadow_we,
    input  logic       sticky_we,
    input  logic       mask_we,
    input  logic       commit,
    input  logic       auto_commit,
    output logic [7:0] ctrl_shadow,
    output logic [7:0] ctrl_active,
    output logic [7:0] status,
    output logic [7:0] sticky,
    output logic [7:0] mask,
    output logic       irq_pending
);

    logic [7:0] s1_reg, s2_reg, s3_reg;
    logic [7:0] sticky_reg, mask_reg;
    logic [7:0] shadow_reg, active_reg;
    logic [7:0] sync_rise;
    logic [7:0] clear_bits;

    // Two-flop synchroniser followed by an edge-detect stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 8'h00;
            s2_reg <= 8'h00;
            s3_reg <= 8'h00;
        end else begin
            s1_reg <= status_raw;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign sync_rise  = s2_reg & ~s3_reg;
    assign clear_bits = sticky_we ? wdata : 8'h00;

    // Sticky capture: a set event in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_reg <= 8'h00;
            mask_reg   <= 8'h00;
        end else begin
            sticky_reg <= (sticky_reg & ~clear_bits) | sync_rise;
            if (mask_we) begin
                mask_reg <= wdata;
            end
        end
    end

    // Shadow/active control; commit copies the pre-edge shadow value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= CTRL_RST;
            active_reg <= CTRL_RST;
        end else begin
            if (shadow_we) begin
                shadow_reg <= wdata;
            end
            if (commit) begin
                active_reg <= shadow_reg;
            end else if (shadow_we && auto_commit) begin
                active_reg <= wdata;
            end
        end
    end

    assign ctrl_shadow = shadow_reg;
    assign ctrl_active = active_reg;
    assign status      = s2_reg;
    assign sticky      = sticky_reg;
    assign mask        = mask_reg;
    assign irq_pending = |(sticky_reg & mask_reg);

endmodule

// File: rtl/serdesphy_csr_bank.sv
// Multi-lane SerDes PHY CSR bank: global page, per-lane pages, decode,
// read mux, error reporting and the registered interrupt.
module serdesphy_csr_bank
    import serdesphy_csr_pkg::*;
#(
    parameter int         NUM_LANES = 2,
    parameter logic [7:0] CTRL_RST  = 8'h14,
    parameter logic [7:0] ID_VAL    = 8'h20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serdesphy_csr_bank_if.slave    bus,
    output logic [8*NUM_LANES-1:0] lane_ctrl,
    input  logic [8*NUM_LANES-1:0] lane_status,
    output logic                   irq
);

    logic [7:0] scratch_reg, gctrl_reg;
    logic [7:0] rdata_reg;
    logic       rvalid_reg, err_reg, irq_reg;

    logic [3:0] ofs;
    logic       ofs_ok, global_hit, mapped, read_only, wr_ok, commit_en;
    logic [NUM_LANES-1:0] lane_hit, irq_vec;
    logic [7:0] irq_sum, rd_val;

    logic [7:0] shadow_arr [NUM_LANES];
    logic [7:0] active_arr [NUM_LANES];
    logic [7:0] status_arr [NUM_LANES];
    logic [7:0] sticky_arr [NUM_LANES];
    logic [7:0] mask_arr   [NUM_LANES];

    assign ofs        = bus.reg_addr[3:0];
    assign ofs_ok     = (ofs <= OFS_MASK);
    assign global_hit = (bus.reg_addr[7:4] == 4'h0) && ofs_ok;
    assign mapped     = global_hit || (|lane_hit);
    assign read_only  = (global_hit && (bus.reg_addr == ADDR_ID || bus.reg_addr == ADDR_IRQ_SUM))
                     || ((|lane_hit) && (ofs == OFS_ACTIVE || ofs == OFS_STATUS));
    assign wr_ok      = bus.reg_write_en && mapped && !read_only;
    assign commit_en  = wr_ok && (bus.reg_addr == ADDR_COMMIT);
    assign irq_sum    = 8'(irq_vec);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_hit[gi] = ((bus.reg_addr & 8'hF0) == lane_base(gi)) && ofs_ok;

        serdesphy_csr_lane #(
            .CTRL_RST (CTRL_RST)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .status_raw  (lane_status[8*gi +: 8]),
            .wdata       (bus.reg_wdata),
            .shadow_we   (wr_ok && lane_hit[gi] && ofs == OFS_CTRL),
            .sticky_we   (wr_ok && lane_hit[gi] && ofs == OFS_STICKY),
            .mask_we     (wr_ok && lane_hit[gi] && ofs == OFS_MASK),
            .commit      (commit_en && bus.reg_wdata[gi]),
            .auto_commit (gctrl_reg[GCTRL_AUTO_COMMIT]),
            .ctrl_shadow (shadow_arr[gi]),
            .ctrl_active (active_arr[gi]),
            .status      (status_arr[gi]),
            .sticky      (sticky_arr[gi]),
            .mask        (mask_arr[gi]),
            .irq_pending (irq_vec[gi])
        );

        assign lane_ctrl[8*gi +: 8] = active_arr[gi];
    end

    // Read mux over pre-edge state; unmapped and write-only locations read 0
    always_comb begin
        rd_val = 8'h00;
        if (global_hit) begin
            case (bus.reg_addr)
                ADDR_ID:      rd_val = {ID_VAL[7:4], 4'(NUM_LANES)};
                ADDR_SCRATCH: rd_val = scratch_reg;
                ADDR_IRQ_SUM: rd_val = irq_sum;
                ADDR_GCTRL:   rd_val = gctrl_reg;
                default:      rd_val = 8'h00;
            endcase
        end
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_hit[l]) begin
                case (ofs)
                    OFS_CTRL:   rd_val = shadow_arr[l];
                    OFS_ACTIVE: rd_val = active_arr[l];
                    OFS_STATUS: rd_val = status_arr[l];
                    OFS_STICKY: rd_val = sticky_arr[l];
                    OFS_MASK:   rd_val = mask_arr[l];
                    default:    rd_val = 8'h00;
                endcase
            end
        end
    end

    // Global read/write registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_reg <= 8'h00;
            gctrl_reg   <= 8'h00;
        end else if (wr_ok && global_hit) begin
            if (bus.reg_addr == ADDR_SCRATCH) begin
                scratch_reg <= bus.reg_wdata;
            end
            if (bus.reg_addr == ADDR_GCTRL) begin
                gctrl_reg <= bus.reg_wdata;
            end
        end
    end

    // Registered bus response and interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg  <= 8'h00;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            rvalid_reg <= bus.reg_read_en;
            rdata_reg  <= bus.reg_read_en ? rd_val : 8'h00;
            err_reg    <= (bus.reg_read_en && !mapped)
                       || (bus.reg_write_en && (!mapped || read_only));
            irq_reg    <= |irq_vec;
        end
    end

    assign bus.reg_rdata  = rdata_reg;
    assign bus.reg_rvalid = rvalid_reg;
    assign bus.reg_err    = err_reg;
    assign irq            = irq_reg;

endmodule

// File: tb/tb_serdesphy_csr_bank.sv
// Bench for serdesphy_csr_bank: directed register scenarios plus random
// traffic, checked every cycle against a behavioural register-map model.
module tb_serdesphy_csr_bank;

    localparam int NL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [8*NL-1:0] lane_ctrl;
    logic [8*NL-1:0] lane_status;
    logic            irq;

    serdesphy_csr_bank_if bus();

    serdesphy_csr_bank #(
        .NUM_LANES (NL),
        .CTRL_RST  (8'h14),
        .ID_VAL    (8'h20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .lane_ctrl   (lane_ctrl),
        .lane_status (lane_status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_shadow [NL];
    logic [7:0] m_active [NL];
    logic [7:0] m_sticky [NL];
    logic [7:0] m_mask   [NL];
    logic [7:0] m_seen1  [NL];   // raw status seen 1 edge ago
    logic [7:0] m_seen2  [NL];   // 2 edges ago (what STATUS shows)
    logic [7:0] m_seen3  [NL];   // 3 edges ago
    logic [7:0] m_rise   [NL];
    logic [7:0] m_clr    [NL];
    logic [7:0] m_scratch, m_gctrl;
    logic [7:0] exp_rdata;
    logic       exp_rvalid, exp_err, exp_irq;

    function automatic bit is_mapped(input logic [7:0] a);
        int ai = int'(a);
        if (ai <= 4) return 1'b1;
        return (ai >= 16) && (ai < 16 * (NL + 1)) && ((ai % 16) <= 4);
    endfunction

    function automatic bit is_ro(input logic [7:0] a);
        int ai = int'(a);
        if (!is_mapped(a)) return 1'b0;
        if (ai < 16) return (ai == 0) || (ai == 3);
        return ((ai % 16) == 1) || ((ai % 16) == 2);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        int ai = int'(a);
        logic [7:0] v = 8'h00;
        if (!is_mapped(a)) return 8'h00;
        if (ai < 16) begin
            case (ai)
                0: v = 8'h20 | 8'(NL);
                1: v = m_scratch;
                3: for (int l = 0; l < NL; l++) v[l] = |(m_sticky[l] & m_mask[l]);
                4: v = m_gctrl;
                default: v = 8'h00;
            endcase
        end else begin
            case (ai % 16)
                0: v = m_shadow[ai / 16 - 1];
                1: v = m_active[ai / 16 - 1];
                2: v = m_seen2[ai / 16 - 1];
                3: v = m_sticky[ai / 16 - 1];
                default: v = m_mask[ai / 16 - 1];
            endcase
        end
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
                m_shadow[l] = 8'h14; m_active[l] = 8'h14;
                m_sticky[l] = 8'h00; m_mask[l]   = 8'h00;
                m_seen1[l]  = 8'h00; m_seen2[l]  = 8'h00; m_seen3[l] = 8'h00;
            end
            m_scratch = 8'h00; m_gctrl = 8'h00;
            exp_rdata = 8'h00; exp_rvalid = 1'b0; exp_err = 1'b0; exp_irq = 1'b0;
        end else begin
            logic [7:0] a;
            int ai, li;
            a  = bus.reg_addr;
            ai = int'(a);
            li = ai / 16 - 1;
            // responses come from the state before this edge
            exp_rvalid = bus.reg_read_en;
            exp_rdata  = bus.reg_read_en ? model_read(a) : 8'h00;
            exp_err    = (bus.reg_read_en && !is_mapped(a))
                      || (bus.reg_write_en && (!is_mapped(a) || is_ro(a)));
            exp_irq    = 1'b0;
            for (int l = 0; l < NL; l++) begin
                exp_irq = exp_irq | (|(m_sticky[l] & m_mask[l]));
                m_rise[l]  = m_seen2[l] & ~m_seen3[l];
                m_clr[l]   = 8'h00;
                m_seen3[l] = m_seen2[l];
                m_seen2[l] = m_seen1[l];
                m_seen1[l] = lane_status[8*l +: 8];
            end
            if (bus.reg_write_en && is_mapped(a) && !is_ro(a)) begin
                if (ai == 1) m_scratch = bus.reg_wdata;
                if (ai == 4) m_gctrl = bus.reg_wdata;
                if (ai == 2) begin
                    for (int l = 0; l < NL; l++)
                        if (bus.reg_wdata[l]) m_active[l] = m_shadow[l];
                end
                if (ai >= 16) begin
                    case (ai % 16)
                        0: begin
                            if (m_gctrl[0]) m_active[li] = bus.reg_wdata;
                            m_shadow[li] = bus.reg_wdata;
                        end
                        3: m_clr[li] = bus.reg_wdata;
                        4: m_mask[li] = bus.reg_wdata;
                        default: ;
                    endcase
                end
            end
            for (int l = 0; l < NL; l++)
                m_sticky[l] = (m_sticky[l] & ~m_clr[l]) | m_rise[l];
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("rvalid", 32'(bus.reg_rvalid), 32'(exp_rvalid));
        check("err", 32'(bus.reg_err), 32'(exp_err));
        check("irq", 32'(irq), 32'(exp_irq));
        for (int l = 0; l < NL; l++)
            check($sformatf("lane_ctrl%0d", l), 32'(lane_ctrl[8*l +: 8]), 32'(m_active[l]));
        if (exp_rvalid)
            check("rdata", 32'(bus.reg_rdata), 32'(exp_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.reg_addr = a; bus.reg_wdata = d;
        bus.reg_write_en = 1'b1; bus.reg_read_en = 1'b0;
        step();
        bus.reg_write_en = 1'b0;
        $display("write 0x%02h = 0x%02h  err=%0b", a, d, bus.reg_err);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_e, input string name);
        bus.reg_addr = a; bus.reg_read_en = 1'b1; bus.reg_write_en = 1'b0;
        step();
        bus.reg_read_en = 1'b0;
        $display("read  0x%02h -> 0x%02h rvalid=%0b err=%0b", a, bus.reg_rdata, bus.reg_rvalid, bus.reg_err);
        check(name, 32'(bus.reg_rdata), 32'(exp_d));
        check({name, "_rvalid"}, 32'(bus.reg_rvalid), 32'd1);
        check({name, "_err"}, 32'(bus.reg_err), 32'(exp_e));
    endtask

    logic [7:0] pool [0:17] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h30};

    task automatic random_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            bus.reg_addr     = pool[$urandom_range(0, 17)];
            bus.reg_wdata    = 8'($urandom);
            bus.reg_read_en  = (op <= 3) || (op == 8);
            bus.reg_write_en = (op >= 4) && (op <= 8);
            lane_status      = lane_status ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            step();
        end
        bus.reg_read_en  = 1'b0;
        bus.reg_write_en = 1'b0;
    endtask

    initial begin
        bus.reg_addr = 8'h00; bus.reg_wdata = 8'h00;
        bus.reg_write_en = 1'b0; bus.reg_read_en = 1'b0;
        lane_status = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_lane_ctrl", 32'(lane_ctrl), 32'h1414);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rvalid", 32'(bus.reg_rvalid), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset contents
        rd(8'h00, 8'h22, 1'b0, "id");
        rd(8'h11, 8'h14, 1'b0, "active0_reset");
        check("lane_ctrl_reset", 32'(lane_ctrl), 32'h1414);
        check("irq_reset", 32'(irq), 32'd0);

        // Shadow write does not reach active until commit
        wr(8'h10, 8'h07);
        rd(8'h11, 8'h14, 1'b0, "active0_precommit");
        check("lane0_precommit", 32'(lane_ctrl[7:0]), 32'h14);
        wr(8'h02, 8'h01);
        check("lane0_commit", 32'(lane_ctrl[7:0]), 32'h07);
        check("lane1_untouched", 32'(lane_ctrl[15:8]), 32'h14);
        rd(8'h02, 8'h00, 1'b0, "commit_reads0");
        wr(8'h02, 8'hFC);
        check("commit_hi_no_err", 32'(bus.reg_err), 32'd0);

        // Auto-commit
        wr(8'h04, 8'h01);
        wr(8'h20, 8'h0B);
        check("lane1_auto", 32'(lane_ctrl[15:8]), 32'h0B);
        rd(8'h21, 8'h0B, 1'b0, "active1_auto");

        // Sticky capture and interrupt
        wr(8'h14, 8'h01);
        lane_status[0] = 1'b1;
        step();
        lane_status[0] = 1'b0;
        repeat (4) step();
        rd(8'h13, 8'h01, 1'b0, "sticky0");
        check("irq_set", 32'(irq), 32'd1);
        rd(8'h03, 8'h01, 1'b0, "irq_sum");
        wr(8'h13, 8'h01);
        check("irq_lag", 32'(irq), 32'd1);
        step();
        check("irq_clr", 32'(irq), 32'd0);

        // Set wins over a simultaneous W1C
        lane_status[9] = 1'b1;
        step();
        step();
        wr(8'h23, 8'h02);
        rd(8'h23, 8'h02, 1'b0, "set_wins");
        rd(8'h22, 8'h02, 1'b0, "status1");

        // Errors
        rd(8'h30, 8'h00, 1'b1, "unmapped_rd");
        wr(8'h06, 8'h55);
        check("unmapped_wr_err", 32'(bus.reg_err), 32'd1);
        rd(8'h06, 8'h00, 1'b1, "unmapped_rd2");
        wr(8'h00, 8'hFF);
        check("ro_wr_err", 32'(bus.reg_err), 32'd1);
        rd(8'h00, 8'h22, 1'b0, "id_after_ro_wr");

        // Simultaneous read and write: read sees the old value
        wr(8'h01, 8'h5A);
        bus.reg_addr = 8'h01; bus.reg_wdata = 8'hA5;
        bus.reg_write_en = 1'b1; bus.reg_read_en = 1'b1;
        step();
        bus.reg_write_en = 1'b0; bus.reg_read_en = 1'b0;
        check("rw_old_value", 32'(bus.reg_rdata), 32'h5A);
        rd(8'h01, 8'hA5, 1'b0, "rw_new_value");

        // Random traffic
        random_traffic(1500);

        // Reset mid-operation drops a pending response
        bus.reg_addr = 8'h00; bus.reg_read_en = 1'b1;
        step();
        bus.reg_read_en = 1'b0;
        check("pending_rvalid", 32'(bus.reg_rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rvalid", 32'(bus.reg_rvalid), 32'd0);
        check("midrst_lane_ctrl", 32'(lane_ctrl), 32'h1414);
        check("midrst_irq", 32'(irq), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        rd(8'h01, 8'h00, 1'b0, "scratch_after_rst");

        random_traffic(1500);
        repeat (3) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
